// File: rtl/qp_mem_arbiter.sv
// qp_mem_arbiter: shares the single-port query-patch SRAM between the kNN
// engine (e_) and the Wishbone debug path (w_). Engine has priority with a
// starvation guard for Wishbone; wb_mode=1 gives Wishbone exclusive access.
// Mode changes pass through DRAIN so in-flight accesses retire first.
module qp_mem_arbiter #(
  parameter int DATA_WIDTH   = 11,
  parameter int PATCH_SIZE   = 5,
  parameter int ADDR_WIDTH   = 9,
  parameter int STARVE_LIMIT = 4,
  localparam int PW          = PATCH_SIZE * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_mode,
  input  logic                  e_req_valid,
  output logic                  e_req_ready,
  input  logic                  e_req_we,
  input  logic [ADDR_WIDTH-1:0] e_req_addr,
  input  logic [PW-1:0]         e_req_wpatch,
  output logic                  e_rsp_valid,
  output logic [PW-1:0]         e_rsp_rpatch,
  input  logic                  w_req_valid,
  output logic                  w_req_ready,
  input  logic                  w_req_we,
  input  logic [ADDR_WIDTH-1:0] w_req_addr,
  input  logic [PW-1:0]         w_req_wpatch,
  output logic                  w_rsp_valid,
  output logic [PW-1:0]         w_rsp_rpatch,
  output logic                  mem_csb0,
  output logic                  mem_web0,
  output logic [ADDR_WIDTH-1:0] mem_addr0,
  output logic [PW-1:0]         mem_wpatch0,
  input  logic [PW-1:0]         mem_rpatch0
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {ST_ENG = 2'd0, ST_WBS = 2'd1, ST_DRAIN = 2'd2} state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [PW-1:0]         wpatch;
  } req_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   starve_cnt;
  logic            starved;
  logic            e_gnt, w_gnt, gnt;
  req_t            sel_req;
  // stage 1 = SRAM command cycle, stage 2 = response cycle
  logic [2:1]      vld_pipe;
  logic [2:1]      own_pipe;   // 1 = Wishbone owns the access
  logic [2:1]      we_pipe;
  logic [PW-1:0]   rd_data;

  assign starved = (starve_cnt == STARVE_MAX);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ENG;
    else        state <= state_nxt;
  end

  // Next state: DRAIN leaves once the command stage is empty; with no grants
  // in DRAIN the response stage is then empty after this edge too.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ENG:   if (wb_mode)  state_nxt = ST_DRAIN;
      ST_WBS:   if (!wb_mode) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!vld_pipe[1]) state_nxt = wb_mode ? ST_WBS : ST_ENG;
      default:  state_nxt = ST_ENG;
    endcase
  end

  // Ready per port; held low while in reset so nothing is granted
  always_comb begin
    e_req_ready = 1'b0;
    w_req_ready = 1'b0;
    if (rst_n) begin
      case (state)
        ST_ENG: begin
          e_req_ready = !(w_req_valid && starved);
          w_req_ready = !e_req_valid || starved;
        end
        ST_WBS:  w_req_ready = 1'b1;
        default: ;
      endcase
    end
  end

  assign e_gnt   = e_req_valid & e_req_ready;
  assign w_gnt   = w_req_valid & w_req_ready;
  assign gnt     = e_gnt | w_gnt;
  assign sel_req = w_gnt ? {w_req_we, w_req_addr, w_req_wpatch}
                         : {e_req_we, e_req_addr, e_req_wpatch};

  // Starvation counter: counts Wishbone wait cycles in engine mode only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          starve_cnt <= '0;
    else if (state != ST_ENG || w_gnt)   starve_cnt <= '0;
    else if (w_req_valid && !starved)    starve_cnt <= starve_cnt + SW'(1);
  end

  // Owner/valid/we tags travel alongside the access through both stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      own_pipe <= '0;
      we_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], gnt};
      own_pipe <= {own_pipe[1], w_gnt};
      we_pipe  <= {we_pipe[1],  gnt & sel_req.we};
    end
  end

  // Registered SRAM command; address/data hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_csb0    <= 1'b1;
      mem_web0    <= 1'b1;
      mem_addr0   <= '0;
      mem_wpatch0 <= '0;
    end else begin
      mem_csb0 <= ~gnt;
      mem_web0 <= ~(gnt & sel_req.we);
      if (gnt) begin
        mem_addr0   <= sel_req.addr;
        mem_wpatch0 <= sel_req.wpatch;
      end
    end
  end

  // SRAM read data arrives in the response cycle; writes return zero
  assign rd_data      = we_pipe[2] ? '0 : mem_rpatch0;
  assign e_rsp_valid  = vld_pipe[2] & ~own_pipe[2];
  assign w_rsp_valid  = vld_pipe[2] &  own_pipe[2];
  assign e_rsp_rpatch = e_rsp_valid ? rd_data : '0;
  assign w_rsp_rpatch = w_rsp_valid ? rd_data : '0;

endmodule

// File: doc/qp_mem_arbiter.md
Name: qp_mem_arbiter

Overview:
- Shares the single-port query-patch SRAM between two requesters:
  - the kNN search engine (e_ port);
  - the Wishbone debug slave path (w_ port).
- Drives OpenRAM-style csb0/web0/addr0/wpatch0 signals from registers.
- Routes read data back to whichever requester issued the access.
- In normal mode the engine has priority, with a starvation guard for Wishbone. In debug mode (wb_mode=1) Wishbone has exclusive access. Mode changes are made safe by draining in-flight accesses first.

Parameters:
- DATA_WIDTH, 11, bits per patch element.
- PATCH_SIZE, 5, elements per patch; PW = PATCH_SIZE*DATA_WIDTH = 55.
- ADDR_WIDTH, 9, SRAM address width (covers 24*17 = 408 queries).
- STARVE_LIMIT, 4, Wishbone wait cycles tolerated before a forced grant (≥1).

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- wb_mode  in  1  0 = engine mode, 1 = Wishbone-exclusive debug mode.
- e_req_valid  in  1  engine request valid.
- e_req_ready  out  1  engine request accepted this cycle.
- e_req_we  in  1  1 = write, 0 = read.
- e_req_addr  in  ADDR_WIDTH  engine address.
- e_req_wpatch  in  PW  engine write data.
- e_rsp_valid  out  1  engine response pulse.
- e_rsp_rpatch  out  PW  engine read data.
- w_req_valid, w_req_ready, w_req_we, w_req_addr, w_req_wpatch, w_rsp_valid, w_rsp_rpatch: same as the e_ port, for Wishbone.
- mem_csb0  out  1  SRAM chip select, active low.
- mem_web0  out  1  SRAM write enable, active low.
- mem_addr0  out  ADDR_WIDTH  SRAM address.
- mem_wpatch0  out  PW  SRAM write data.
- mem_rpatch0  in  PW  SRAM read data.

Behaviour:
- Reset values:
  - mem_csb0=1, mem_web0=1, mem_addr0=0, mem_wpatch0=0.
  - Both req_ready=0, both rsp_valid=0, both rsp_rpatch=0.
  - Starvation counter = 0, pipeline tags cleared, FSM=ENG.
- Handshake: a request is granted in cycle A when valid&ready. At most one grant per cycle. A requester must hold its request fields stable while valid and not yet ready. ready is combinational from the FSM state, the valids and the starvation counter.
- Pipeline (fully pipelined, one access per cycle, at most 2 accesses in flight):
  - Cycle A+1: registered SRAM command. mem_csb0=0, mem_web0=~we, mem_addr0=addr, mem_wpatch0=wpatch.
  - Cycle A+1 with no grant in A: mem_csb0=1, mem_web0=1; addr/wpatch hold their previous values.
  - Cycle A+2: the owner's rsp_valid=1 for exactly 1 cycle. rsp_rpatch = mem_rpatch0 for reads and 0 for writes. The other port's rsp_valid=0.
  - The owner tag travels with the command through both pipeline stages.
- FSM states:
  - ENG (wb_mode=0):
    - Default: engine is granted whenever e_req_valid=1.
    - Wishbone is granted only if e_req_valid=0, or if starve_cnt==STARVE_LIMIT (forced grant; engine not ready that cycle).
    - starve_cnt increments each cycle with w_req_valid=1 and no Wishbone grant. It clears on any Wishbone grant and saturates at STARVE_LIMIT.
  - WBS (wb_mode=1): e_req_ready=0 always. Wishbone is granted whenever w_req_valid=1. starve_cnt is held at 0.
  - DRAIN:
    - Entered from ENG or WBS in the cycle after wb_mode differs from the current state's mode.
    - No grants while in DRAIN.
    - Exits to ENG or WBS (per the current wb_mode) once both pipeline stages are empty, i.e. at most 2 cycles.
    - A wb_mode toggle during DRAIN is tracked: the exit state follows the final wb_mode.
- The cycle in which wb_mode toggles still arbitrates under the old state. That grant completes normally and its response goes to the requester that issued it.
- Simultaneous valid on both ports is resolved only by the rules above; there is no round-robin.
- No address range check: addr is passed through unchanged.
- Reset mid-operation: all in-flight accesses are discarded, no responses are issued, and mem_csb0 goes to 1 asynchronously.

Test Plan:
- Reset: hold rst_n=0 with both valids=1 -> mem_csb0=1, mem_web0=1, both ready=0, no rsp_valid. After release, FSM=ENG and the engine is granted on the first cycle.
- Engine read: addr=5 granted in cycle A; bench drives mem_rpatch0=55'h00_1010_DEAD_BEEF -> mem_csb0=0, mem_web0=1, mem_addr0=5 in A+1; e_rsp_valid=1 with e_rsp_rpatch=55'h00_1010_DEAD_BEEF in A+2; w_rsp_valid=0.
- Starvation: both valid continuously from cycle 0, STARVE_LIMIT=4 -> engine granted in cycles 0-3, Wishbone in cycle 4, engine again in cycles 5-8, Wishbone in cycle 9.
- Mode switch: engine read granted in A, wb_mode=1 in A -> no grants in A+1..A+2; e_rsp_valid in A+2. FSM reaches WBS; Wishbone write (addr=2, wpatch=55'h0B_CDEF_0123_4567) granted in A+3 -> mem_web0=0, mem_addr0=2 in A+4; w_rsp_valid in A+5.
- WBS exclusivity: e_req_valid=1 held for 20 cycles while wb_mode=1 -> e_req_ready=0 throughout; Wishbone back-to-back reads to addrs 1,2,3 produce three consecutive w_rsp_valid pulses.
- Reset mid-op: rst_n=0 in A+1 after a Wishbone read granted in A -> mem_csb0=1 immediately; no rsp_valid in A+2.
